// File: rtl/alu_operand_loader_pkg.sv
// Shared types and default widths for the ALU operand path.
// The operand loader's FSM state encoding doubles as the LED stage code.
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int OP_WIDTH  = 4;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        ISSUE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Board-side bundle of the operand loader: switches, buttons, captured operands and status.
// The slave modport is the loader's view; the master modport is the driver's view.
interface alu_operand_loader_if #(
    parameter int WIDTH    = 4,
    parameter int OP_WIDTH = 4
);
    logic [9:0]          sw;
    logic                btn_next;
    logic                btn_clear;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [OP_WIDTH-1:0] op;
    logic                valid;
    logic [1:0]          stage;

    modport slave  (input  sw, btn_next, btn_clear,
                    output a, b, op, valid, stage);
    modport master (output sw, btn_next, btn_clear,
                    input  a, b, op, valid, stage);
endinterface

// File: rtl/alu_operand_loader_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a one-cycle press pulse.
// Raw edge to press pulse takes 2 + DEBOUNCE_CYCLES clocks.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronised input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/alu_operand_loader.sv
// Collects operand A, operand B and the opcode from the switches on successive "next" presses,
// then pulses valid for one cycle with all three held stable.
module alu_operand_loader #(
    parameter int WIDTH           = alu_pkg::ALU_WIDTH,
    parameter int OP_WIDTH        = alu_pkg::OP_WIDTH,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_loader_if.slave  bus
);
    import alu_pkg::*;

    logic next_press, clear_press;
    logic next_level, clear_level;
    logic unused_bits;

    loader_state_t       state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic                valid_q, valid_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_next),
        .level   (next_level),
        .press   (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_clear),
        .level   (clear_level),
        .press   (clear_press)
    );

    // Held levels and the upper switch bits have no consumer here.
    assign unused_bits = ^{next_level, clear_level, bus.sw};

    // Clear overrides everything, including a coincident next press.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = 1'b0;
        if (clear_press) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else begin
            case (state_q)
                WAIT_A: if (next_press) begin
                    a_d     = bus.sw[WIDTH-1:0];
                    state_d = WAIT_B;
                end
                WAIT_B: if (next_press) begin
                    b_d     = bus.sw[WIDTH-1:0];
                    state_d = WAIT_OP;
                end
                WAIT_OP: if (next_press) begin
                    op_d    = bus.sw[OP_WIDTH-1:0];
                    state_d = ISSUE;
                    valid_d = 1'b1;
                end
                ISSUE:   state_d = WAIT_A;
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.op    = op_q;
    assign bus.valid = valid_q;
    assign bus.stage = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_operand_loader_if #(.WIDTH(4), .OP_WIDTH(4)) bus ();

    alu_operand_loader #(.WIDTH(4), .OP_WIDTH(4), .DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold next for 10 cycles then release for 10; counts valid highs seen meanwhile.
    task automatic press_next(input logic [9:0] v, output int vcnt);
        vcnt = 0;
        bus.sw = v;
        bus.btn_next = 1'b1;
        repeat (10) begin @(negedge clk); vcnt += int'(bus.valid); end
        bus.btn_next = 1'b0;
        repeat (10) begin @(negedge clk); vcnt += int'(bus.valid); end
    endtask

    task automatic press_clear();
        bus.btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int vc;
        int hits;
        int first_hit;
        logic [3:0] a_at_v, b_at_v, op_at_v;

        bus.sw = '0;
        bus.btn_next = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a", bus.a, 0);
        check("rst_stage", bus.stage, 0);
        check("rst_valid", bus.valid, 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a load
        press_next(10'd5, vc);
        press_next(10'd1, vc);
        check("mid_a", bus.a, 5);
        check("mid_stage", bus.stage, 2);
        rst = 1'b0;
        #1;
        check("arst_a", bus.a, 0);
        check("arst_b", bus.b, 0);
        check("arst_op", bus.op, 0);
        check("arst_stage", bus.stage, 0);
        check("arst_valid", bus.valid, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_stage", bus.stage, 0);
        check("post_rst_a", bus.a, 0);

        // Full load with latency measurement on the opcode press
        press_next(10'd3, vc);
        check("load_a", bus.a, 3);
        check("load_a_stage", bus.stage, 1);
        press_next(10'd6, vc);
        check("load_b", bus.b, 6);
        check("load_b_stage", bus.stage, 2);
        bus.sw = 10'd2;
        bus.btn_next = 1'b1;
        hits = 0;
        first_hit = -1;
        a_at_v = '0; b_at_v = '0; op_at_v = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                hits++;
                if (first_hit < 0) begin
                    first_hit = i;
                    a_at_v = bus.a; b_at_v = bus.b; op_at_v = bus.op;
                end
            end
        end
        check("valid_latency", first_hit, 7);
        check("valid_width", hits, 1);
        check("valid_a", a_at_v, 3);
        check("valid_b", b_at_v, 6);
        check("valid_op", op_at_v, 2);
        @(negedge clk);
        bus.btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check("after_issue_stage", bus.stage, 0);

        // Bounce rejection, then a long hold gives one capture
        bus.sw = 10'd9;
        for (int k = 0; k < 4; k++) begin
            bus.btn_next = (k % 2 == 0);
            repeat (2) @(negedge clk);
        end
        bus.btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_stage", bus.stage, 0);
        check("bounce_a", bus.a, 3);
        bus.btn_next = 1'b1;
        repeat (20) @(negedge clk);
        bus.btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_stage", bus.stage, 1);
        check("hold_a", bus.a, 9);

        // Clear and next together in WAIT_OP
        press_next(10'd4, vc);
        check("pre_clr_stage", bus.stage, 2);
        bus.btn_next = 1'b1;
        bus.btn_clear = 1'b1;
        vc = 0;
        repeat (10) begin @(negedge clk); vc += int'(bus.valid); end
        bus.btn_next = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (10) begin @(negedge clk); vc += int'(bus.valid); end
        check("clr_stage", bus.stage, 0);
        check("clr_a", bus.a, 0);
        check("clr_b", bus.b, 0);
        check("clr_op", bus.op, 0);
        check("clr_no_valid", vc, 0);

        // Persistence of b/op across a new A capture
        press_next(10'd1, vc);
        press_next(10'd2, vc);
        press_next(10'd7, vc);
        check("pers_issue_count", vc, 1);
        press_next(10'hF, vc);
        check("pers_a", bus.a, 4'hF);
        check("pers_b", bus.b, 2);
        check("pers_op", bus.op, 7);
        check("pers_stage", bus.stage, 1);
        check("pers_no_valid", vc, 0);

        // Truncation of wide switch value
        press_clear();
        check("trunc_pre_stage", bus.stage, 0);
        press_next(10'h3FA, vc);
        check("trunc_a", bus.a, 4'hA);
        check("trunc_stage", bus.stage, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream stage of the ALU/result-register path; it collects operands and the opcode from the board switches.
- The user sets the switches and presses a "next" button. The block captures A, then B, then the opcode, and issues a one-cycle valid pulse.
- a/b/op stay registered and stable between loads, so the ALU register stage downstream sees constant inputs.
- Includes button synchronisation and debouncing.

Parameters:
- WIDTH, 4, operand width in bits (matches the ALU data path).
- OP_WIDTH, 4, opcode width in bits.
- DEBOUNCE_CYCLES, 50000, number of consecutive stable synchronised samples required before a button level is accepted. Benches use 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sw  in  10  raw slide switches. Operands use sw[WIDTH-1:0]; the opcode uses sw[OP_WIDTH-1:0]. Quasi-static; sampled only on a capture cycle.
- btn_next  in  1  raw push button, active-high, asynchronous to clk.
- btn_clear  in  1  raw push button, active-high, asynchronous to clk.
- a  out  WIDTH  captured operand A.
- b  out  WIDTH  captured operand B.
- op  out  OP_WIDTH  captured opcode.
- valid  out  1  one-cycle pulse: {a,b,op} form a new complete operation.
- stage  out  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset (rst=0, asynchronous):
  - a=0, b=0, op=0, valid=0.
  - stage=WAIT_A (2'd0).
  - Synchroniser flops, debounce counters and debounced levels all cleared to 0.
  - Reset mid-sequence discards any partial load.
- Button conditioning, per button via btn_debounce:
  - 2-flop synchroniser, then a counter.
  - The counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - Latency from a stable raw edge to the press pulse = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - A held button yields exactly one pulse, with no auto-repeat.
  - Release is also debounced; it produces no pulse.
- FSM states, encoded on stage:
  - WAIT_A (0): on next_press, a<=sw[WIDTH-1:0], go to WAIT_B.
  - WAIT_B (1): on next_press, b<=sw[WIDTH-1:0], go to WAIT_OP.
  - WAIT_OP (2): on next_press, op<=sw[OP_WIDTH-1:0], go to ISSUE.
  - ISSUE (3): valid=1 for exactly this cycle, then unconditionally go to WAIT_A. A next_press arriving in ISSUE is dropped.
- valid is registered:
  - It is high exactly during the ISSUE cycle, which is the cycle after op is captured.
  - a, b and op are already stable when valid rises.
- clear_press, in any state:
  - Return to WAIT_A and zero a, b, op.
  - valid=0 in the following cycle.
- Simultaneous clear_press and next_press: clear wins; nothing is captured.
- a, b and op hold their values until overwritten or cleared. A new A capture does not alter the old b/op until those stages are reloaded.
- No arithmetic is performed. Widths are truncated slices of sw; WIDTH and OP_WIDTH must be ≤10.

Decomposition:
- Shared package alu_pkg holds:
  - loader_state_t enum {WAIT_A=2'd0, WAIT_B=2'd1, WAIT_OP=2'd2, ISSUE=2'd3}.
  - ALU_WIDTH=4 and OP_WIDTH=4 constants.
- Sub-module btn_debounce, parameter DEBOUNCE_CYCLES:
  - Ports: clk, rst, btn_raw, level, press.
  - Instantiated twice (next, clear).
- FSM and capture registers live in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert rst=0 mid-WAIT_OP with a=5 -> immediately a=b=op=0, stage=0, valid=0. After release, nothing changes until a press.
- Full load: sw=3, press; sw=6, press; sw=2, press (each held 10 cycles) -> a=3, b=6, op=2. valid is high for exactly 1 cycle, 7 cycles after the third raw rising edge (2 sync + 4 debounce + 1 ISSUE). Then stage=0.
- Bounce rejection: btn_next toggles 1,0,1,0 each for 2 cycles, then 0 -> no press, stage unchanged. Holding 1 for 20 cycles -> exactly one capture.
- Clear priority: in WAIT_OP with a=9, b=4, assert btn_next and btn_clear together -> stage=0, a=b=op=0, no valid pulse.
- Hold/persistence: after a completed load (a=1, b=2, op=7), load a new A=0xF -> a=0xF, b=2, op=7 unchanged, stage=1, valid stays 0.
- Width truncation: sw=10'h3FA at A capture -> a=4'hA.
